// File: rtl/cla_checker.sv
// Exhaustive self-test sequencer for a WIDTH-bit adder: sweeps every {Cin,A,B} vector,
// compares the adder's {C4,S} after LATENCY cycles and reports mismatch count / first failing index.
module cla_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic               Cin,
  input  logic [WIDTH-1:0]   S,
  input  logic               C4,
  output logic               Busy,
  output logic               Done,
  output logic               Pass,
  output logic [15:0]        ErrCount,
  output logic [2*WIDTH:0]   FirstErr
);

  localparam int VW = 2*WIDTH + 1;
  localparam logic [VW-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [15:0]     err_q, err_d;
  logic [VW-1:0]   first_q, first_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  // Stage j of the delay line holds the vector that was driven j edges ago.
  logic [LATENCY-1:0]          vld_q;
  logic [LATENCY-1:0][WIDTH:0] exp_q;
  logic [LATENCY-1:0][VW-1:0]  idx_q;

  logic            cmp_en;
  logic            mism;
  logic [VW-1:0]   tail_idx;

  function automatic logic [WIDTH:0] ref_sum(input logic [VW-1:0] v);
    ref_sum = {1'b0, v[2*WIDTH-1:WIDTH]} + {1'b0, v[WIDTH-1:0]} + {{WIDTH{1'b0}}, v[VW-1]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    sat_inc = (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    err_d    = err_q;
    first_d  = first_q;
    tail_idx = idx_q[LATENCY-1];
    cmp_en   = vld_q[LATENCY-1] && ((state_q == RUN) || (state_q == DRAIN));
    mism     = cmp_en && ({C4, S} != exp_q[LATENCY-1]);

    if (mism) begin
      err_d = sat_inc(err_q);
      if (err_q == 16'd0) first_d = tail_idx;
    end

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          vec_d   = '0;
          err_d   = '0;
          first_d = '0;
        end
      end
      RUN: begin
        if (vec_q == LAST) begin
          vec_d   = '0;
          state_d = (LATENCY == 1) ? DONE : DRAIN;
        end else begin
          vec_d = vec_q + VW'(1);
        end
      end
      DRAIN: begin
        // The last vector reaching the tail marks the final comparison.
        if (cmp_en && (tail_idx == LAST)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == 16'd0);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      vld_q   <= '0;
      exp_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      first_q  <= first_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      vld_q[0] <= (state_d == RUN);
      exp_q[0] <= ref_sum(vec_d);
      idx_q[0] <= vec_d;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign A        = vec_q[2*WIDTH-1:WIDTH];
  assign B        = vec_q[WIDTH-1:0];
  assign Cin      = vec_q[VW-1];
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Pass     = pass_q;
  assign ErrCount = err_q;
  assign FirstErr = first_q;

endmodule

// File: doc/cla_checker.md
CLA_CHECKER -- requirements
Module: cla_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width of the adder under check; legal range 2..7.
REQ-002 SHALL have parameter LATENCY, default 1, adder output latency in Clk cycles; legal range 1..4.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Clk  in  1  clock; all state updates on rising edge.
REQ-005 Rst  in  1  asynchronous active-low reset.
REQ-006 Start  in  1  launch request, sampled on rising Clk.
REQ-007 A  out  WIDTH  operand A driven to the adder.
REQ-008 B  out  WIDTH  operand B driven to the adder.
REQ-009 Cin  out  1  carry-in driven to the adder.
REQ-010 S  in  WIDTH  sum returned by the adder.
REQ-011 C4  in  1  carry-out returned by the adder.
REQ-012 Busy  out  1  high in RUN and DRAIN.
REQ-013 Done  out  1  high in DONE.
REQ-014 Pass  out  1  high in DONE when ErrCount is 0; low otherwise.
REQ-015 ErrCount  out  16  mismatch count, saturating at 0xFFFF.
REQ-016 FirstErr  out  2*WIDTH+1  index {Cin,A,B} of the first mismatching vector; 0 if none.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 Vector index SHALL be a (2*WIDTH+1)-bit count v = {Cin,A,B}, with B least significant; N = 2^(2*WIDTH+1) vectors (512 at WIDTH=4).
REQ-019 IDLE: Start=1 at edge k -> RUN; A/B/Cin = vector 0 after edge k; ErrCount and FirstErr cleared at edge k.
REQ-020 RUN: the vector SHALL advance by exactly 1 per edge; vector n is driven after edge k+n.
REQ-021 Vector N-1 is driven after edge k+N-1. At edge k+N, A/B/Cin SHALL return to 0 and the state SHALL go to DRAIN, or directly to DONE if LATENCY=1.
REQ-022 Expected value SHALL be the (WIDTH+1)-bit sum A+B+Cin. The expected value and index SHALL be carried through a LATENCY-deep valid-tagged delay line.
REQ-023 The vector driven after edge m SHALL be compared with {C4,S} sampled at edge m+LATENCY.
REQ-024 On a mismatch, ErrCount SHALL increment (saturating). On the first mismatch only, FirstErr SHALL capture the index.
REQ-025 DRAIN SHALL last LATENCY-1 cycles. DONE is entered on the edge at which the final comparison (vector N-1) is sampled, edge k+N-1+LATENCY; ErrCount includes that comparison.
REQ-026 In IDLE and DONE, no comparisons SHALL occur and S/C4 SHALL be ignored.
REQ-027 Start in RUN or DRAIN SHALL be ignored.
REQ-028 Start in DONE SHALL behave as in IDLE (REQ-019): restart, clear results, drop Done and Pass.
REQ-029 Without Start, DONE SHALL hold Done, Pass, ErrCount and FirstErr indefinitely.
REQ-030 Outputs SHALL be registered; no combinational path from S/C4/Start to any output.

Reset
REQ-031 Rst low SHALL immediately force IDLE, clear the delay line, and force all outputs to 0.
REQ-032 Reset mid-RUN/DRAIN SHALL abandon the run; after Rst rises, nothing happens until Start.

Verification
REQ-033 Correct adder model, LATENCY=1, Start pulse at edge k -> Done=1 after edge k+512, Busy low, Pass=1, ErrCount=0, FirstErr=0.
REQ-034 Model with S[0] stuck at 0 -> ErrCount=256, Pass=0, FirstErr=0x001.
REQ-035 Model with C4 stuck at 0 -> ErrCount=256, Pass=0, FirstErr=0x01F.
REQ-036 LATENCY=2 with a 2-cycle model -> Pass=1, Done after edge k+513. The same model with LATENCY=1 -> Pass=0, ErrCount>0.
REQ-037 Rst low for 1 cycle at cycle 100 of RUN -> all outputs 0 at once; stays IDLE. A fresh Start gives a full 512-vector run, Pass=1.
REQ-038 Start held high throughout the run -> single run, Done at edge k+512. With Start still high in DONE, a new run starts and Done drops next cycle.
